// File: rtl/pipe_pkg.sv
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared pipeline control-bundle layout, widths and ALU encodings.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    localparam int c_ALUSRC_W   = 2;
    localparam int c_ALUCTRL_W  = 5;
    localparam int c_REGDST_W   = 2;
    localparam int c_MEMTOREG_W = 2;
    localparam int c_PCSRC_W    = 2;

    typedef struct packed {
        logic [c_ALUSRC_W-1:0]   alu_src;
        logic [c_ALUCTRL_W-1:0]  alu_ctrl;
        logic                    sign;
        logic [c_REGDST_W-1:0]   reg_dst;
        logic                    mem_wr;
        logic                    branch;
        logic [c_MEMTOREG_W-1:0] mem_to_reg;
        logic                    reg_wr;
        logic [c_PCSRC_W-1:0]    pc_src;
        logic                    lu_op;
    } idex_ctrl_t;

    localparam int         CTRL_W      = $bits(idex_ctrl_t);
    // All-zero keeps reg_wr/mem_wr deasserted for bubble slots
    localparam idex_ctrl_t BUBBLE_CTRL = '0;

    localparam logic [c_ALUCTRL_W-1:0] c_ALU_ADD = 5'd0;
    localparam logic [c_ALUCTRL_W-1:0] c_ALU_SUB = 5'd1;
    localparam logic [c_ALUCTRL_W-1:0] c_ALU_AND = 5'd2;
    localparam logic [c_ALUCTRL_W-1:0] c_ALU_OR  = 5'd3;
    localparam logic [c_ALUCTRL_W-1:0] c_ALU_XOR = 5'd4;
    localparam logic [c_ALUCTRL_W-1:0] c_ALU_NOR = 5'd5;
    localparam logic [c_ALUCTRL_W-1:0] c_ALU_SLT = 5'd6;
    localparam logic [c_ALUCTRL_W-1:0] c_ALU_SLL = 5'd7;
    localparam logic [c_ALUCTRL_W-1:0] c_ALU_SRL = 5'd8;
    localparam logic [c_ALUCTRL_W-1:0] c_ALU_SRA = 5'd9;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Saturating event counter, holds at all-ones instead of wrapping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_skid.sv
// ============================================================================
// Module : pipe_stage_skid
// Brief  : Inter-stage pipeline register with valid/ready, flush, optional
//          skid entry and saturating stall/flush statistics.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_stage_skid #(
    parameter int                 DATA_W      = 32,
    parameter int                 CTRL_W      = pipe_pkg::CTRL_W,
    parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = pipe_pkg::BUBBLE_CTRL,
    parameter int                 SKID        = 1,
    parameter int                 CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    logic w_accept;
    logic w_drain;

    assign w_accept = in_valid & in_ready;
    assign w_drain  = r_main_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_ctrl  <= BUBBLE_CTRL;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_ctrl  <= BUBBLE_CTRL;
        end else if (flush) begin
            // Data is left in place; only validity and control are squashed
            r_main_valid <= 1'b0;
            r_main_ctrl  <= BUBBLE_CTRL;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || w_drain) begin
            if (r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_main_data  <= r_skid_data;
                r_main_ctrl  <= r_skid_ctrl;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_main_valid <= 1'b1;
                r_main_data  <= in_data;
                r_main_ctrl  <= in_ctrl;
            end else begin
                r_main_valid <= 1'b0;
                r_main_ctrl  <= BUBBLE_CTRL;
            end
        end else if (w_accept && (SKID != 0)) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= in_data;
            r_skid_ctrl  <= in_ctrl;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            // Skid occupancy is registered, so in_ready has no path from out_ready
            assign in_ready = ~r_skid_valid;
        end else begin : g_single
            assign in_ready = out_ready | ~r_main_valid;
        end
    endgenerate

    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;
    assign out_ctrl  = r_main_ctrl;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (r_main_valid & ~out_ready),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush),
        .count (flush_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// ============================================================================
// Module : tb_pipe_stage_skid
// Brief  : Directed self-checking bench with an ordering scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_skid;

    logic        clk;
    logic        reset;

    // SKID=1, CNT_W=16 instance
    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [17:0] in_ctrl, out_ctrl;
    logic [15:0] stall_cnt, flush_cnt;

    // SKID=0 instance
    logic        s0_flush, s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
    logic [31:0] s0_in_data, s0_out_data;
    logic [17:0] s0_in_ctrl, s0_out_ctrl;
    logic [15:0] s0_stall_cnt, s0_flush_cnt;

    // CNT_W=4 instance
    logic        s4_flush, s4_in_valid, s4_in_ready, s4_out_valid, s4_out_ready;
    logic [31:0] s4_in_data, s4_out_data;
    logic [17:0] s4_in_ctrl, s4_out_ctrl;
    logic [3:0]  s4_stall_cnt, s4_flush_cnt;

    int checks   = 0;
    int failures = 0;
    logic [49:0] sb_q[$];
    logic [49:0] sb_exp;

    pipe_stage_skid #(.SKID(1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stage_skid #(.SKID(0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .flush(s0_flush),
        .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_data(s0_in_data), .in_ctrl(s0_in_ctrl),
        .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_data(s0_out_data), .out_ctrl(s0_out_ctrl),
        .stall_cnt(s0_stall_cnt), .flush_cnt(s0_flush_cnt)
    );

    pipe_stage_skid #(.SKID(1), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .flush(s4_flush),
        .in_valid(s4_in_valid), .in_ready(s4_in_ready), .in_data(s4_in_data), .in_ctrl(s4_in_ctrl),
        .out_valid(s4_out_valid), .out_ready(s4_out_ready), .out_data(s4_out_data), .out_ctrl(s4_out_ctrl),
        .stall_cnt(s4_stall_cnt), .flush_cnt(s4_flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] ctrl_of(input logic [31:0] d);
        return d[17:0] ^ 18'h2A5A5;
    endfunction

    task automatic drive(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = ctrl_of(d);
    endtask

    // Scoreboard: push on accepted input, pop and compare on each drain
    always @(negedge clk) begin
        if (reset || flush) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() > 0) sb_exp = sb_q.pop_front();
                else                 sb_exp = '1;
                chk("sb_order", {out_ctrl, out_data}, sb_exp);
            end
            if (!out_valid) chk("bubble_ctrl", out_ctrl, 0);
            if (in_valid && in_ready) sb_q.push_back({in_ctrl, in_data});
        end
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b1;
        s0_flush = 1'b0; s0_in_valid = 1'b0; s0_in_data = '0; s0_in_ctrl = '0; s0_out_ready = 1'b0;
        s4_flush = 1'b0; s4_in_valid = 1'b0; s4_in_data = '0; s4_in_ctrl = '0; s4_out_ready = 1'b0;
        tick; tick;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        reset = 1'b0;

        // Back-to-back stream, one-cycle latency
        for (int i = 1; i <= 3; i++) begin
            drive(32'(4 * i));
            tick;
            chk("stream_valid", out_valid, 1);
            chk("stream_data", out_data, 32'(4 * i));
            chk("stream_ctrl", out_ctrl, ctrl_of(32'(4 * i)));
        end
        in_valid = 1'b0;
        tick;
        chk("stream_empty", out_valid, 0);

        // Back-pressure fills main then skid
        out_ready = 1'b0;
        drive(32'h10); tick;
        chk("stall_in_ready1", in_ready, 1);
        drive(32'h14); tick;
        chk("stall_in_ready0", in_ready, 0);
        drive(32'h18); tick; tick;
        chk("stall_hold_data", out_data, 32'h10);
        chk("stall_hold_ctrl", out_ctrl, ctrl_of(32'h10));
        chk("stall_in_ready_hold", in_ready, 0);
        chk("stall_cnt3", stall_cnt, 3);
        out_ready = 1'b1;
        tick;
        chk("release_skid_data", out_data, 32'h14);
        chk("release_in_ready", in_ready, 1);
        tick;
        chk("release_third", out_data, 32'h18);
        in_valid = 1'b0;
        tick;
        chk("release_empty", out_valid, 0);
        chk("stall_cnt_kept", stall_cnt, 3);

        // Flush a full stage while offering a new word
        out_ready = 1'b0;
        drive(32'h30); tick;
        drive(32'h34); tick;
        drive(32'h20); flush = 1'b1;
        tick;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_out_ctrl", out_ctrl, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_data_held", out_data, 32'h30);
        chk("flush_cnt1", flush_cnt, 1);
        chk("flush_stall_cnt", stall_cnt, 5);
        out_ready = 1'b1;
        tick; tick;
        chk("flush_no_resurrect", out_valid, 0);

        // Asynchronous reset in the middle of a transfer
        out_ready = 1'b0;
        drive(32'h40); tick;
        in_valid = 1'b0;
        chk("pre_reset_valid", out_valid, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_ctrl", out_ctrl, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_stall_cnt", stall_cnt, 0);
        chk("mid_rst_flush_cnt", flush_cnt, 0);
        tick;
        reset = 1'b0;
        out_ready = 1'b1;

        // Single-entry variant: in_ready follows out_ready combinationally
        s0_in_valid = 1'b1; s0_in_data = 32'h50; s0_in_ctrl = ctrl_of(32'h50);
        #1;
        chk("s0_ready_empty", s0_in_ready, 1);
        tick;
        chk("s0_data", s0_out_data, 32'h50);
        chk("s0_ready_full", s0_in_ready, 0);
        s0_in_data = 32'h54; s0_in_ctrl = ctrl_of(32'h54);
        s0_out_ready = 1'b1;
        #1;
        chk("s0_ready_comb", s0_in_ready, 1);
        tick;
        chk("s0_next_data", s0_out_data, 32'h54);
        s0_in_valid = 1'b0;
        tick;
        chk("s0_empty", s0_out_valid, 0);

        // Saturation of a 4-bit stall counter
        s4_in_valid = 1'b1; s4_in_data = 32'h60; s4_in_ctrl = ctrl_of(32'h60);
        tick;
        s4_in_valid = 1'b0;
        repeat (14) tick;
        chk("sat_cnt14", s4_stall_cnt, 14);
        tick;
        chk("sat_cnt15", s4_stall_cnt, 15);
        repeat (5) tick;
        chk("sat_hold15", s4_stall_cnt, 15);
        chk("sat_data_held", s4_out_data, 32'h60);

        tick;
        chk("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
